alu_request_arbiter: RTL and testbench

Sequencer that shares one combinational N-bit ALU, with its 7-segment display path, between two requesters. It accepts one operation at a time over a valid/ready handshake and chooses between simultaneous requests round-robin. It drives the ALU operand and opcode ports from registers, captures the ALU result, and returns it with the winner's ID. It then keeps the display enabled for a programmable hold window. It sits in front of the ALU-plus-decoder display datapath, and its `disp_enable` feeds that datapath's display enable.

---
 rtl/alu_request_arbiter_if.sv | 49 ++++
 rtl/alu_request_arbiter.sv | 115 +++++++++++
 tb/tb_alu_request_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_request_arbiter_if.sv
// Bundle between alu_request_arbiter and its surroundings: two requester
// valid/ready channels, the registered ALU operand/opcode drive, the ALU
// result return, the response channel and the display/busy status.
//   slave  : arbiter side (consumes requests + alu_result, drives the rest)
//   master : requester / ALU / display side
interface alu_request_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic             req1_ready;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             disp_enable;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_opcode,
    output rsp_valid, rsp_id, rsp_data, disp_enable, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_opcode,
    input  rsp_valid, rsp_id, rsp_data, disp_enable, busy
  );
endinterface

// File: rtl/alu_request_arbiter.sv
// Shares one combinational ALU (and its 7-segment display path) between two
// requesters. One operation in flight at a time: IDLE accepts a request
// (round-robin on ties), EXEC presents registered operands to the ALU for one
// cycle and captures the result, HOLD keeps the display enabled for
// HOLD_CYCLES cycles and pulses rsp_valid in its first cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_request_arbiter_if.slave (requests, ALU drive/result,
//                response, disp_enable, busy)
module alu_request_arbiter #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_request_arbiter_if.slave  bus
);
  localparam int NUM_REQ = 2;
  localparam int CNT_W   = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t                            state, state_nxt;
  logic                              last_grant;
  logic [CNT_W-1:0]                  hold_cnt;
  logic                              winner;
  logic                              xfer;

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0]     req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0]     req_b;
  logic [NUM_REQ-1:0][1:0]           req_op;

  logic [WIDTH-1:0]                  alu_a_q, alu_b_q, rsp_data_q;
  logic [1:0]                        alu_op_q;
  logic                              rsp_id_q, rsp_valid_q;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_a     = {bus.req1_a,     bus.req0_a};
  assign req_b     = {bus.req1_b,     bus.req0_b};
  assign req_op    = {bus.req1_op,    bus.req0_op};

  // Tie goes to whoever was not served last; otherwise the lone valid wins.
  always_comb begin
    if (&req_valid) winner = ~last_grant;
    else            winner = req_valid[1] & ~req_valid[0];
  end

  // Ready is combinational and gated by rst_n so nothing is offered while the
  // block is held in reset.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = rst_n && (state == IDLE) && req_valid[i] &&
                          (winner == 1'(i));
  end

  assign xfer           = |req_ready;
  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      hold_cnt    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (xfer) begin
        alu_a_q    <= req_a[winner];
        alu_b_q    <= req_b[winner];
        alu_op_q   <= req_op[winner];
        rsp_id_q   <= winner;
        last_grant <= winner;
      end
      // Registered off EXEC, so it is high only in the first HOLD cycle.
      rsp_valid_q <= (state == EXEC);
      if (state == EXEC) begin
        rsp_data_q <= bus.alu_result;
        hold_cnt   <= CNT_W'(HOLD_CYCLES - 1);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.disp_enable = (state == HOLD);
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter. Two instances: HOLD_CYCLES=8 for the
// table and the multi-cycle sequences, HOLD_CYCLES=1 for back-to-back rate.
// ALU model: alu_result = (alu_a + alu_b) mod 16.
module tb_alu_request_arbiter;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  alu_request_arbiter_if #(.WIDTH(4)) b8 ();
  alu_request_arbiter_if #(.WIDTH(4)) b1 ();

  alu_request_arbiter #(.WIDTH(4), .HOLD_CYCLES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  alu_request_arbiter #(.WIDTH(4), .HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  assign b8.alu_result = b8.alu_a + b8.alu_b;
  assign b1.alu_result = b1.alu_a + b1.alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v0, a0, b0, op0;
    int v1, a1, b1, op1;
    int eid, edata;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input int v0, a0, b0, op0, v1, a1, b1, op1, eid, edata);
    vec_t m;
    m.v0 = v0; m.a0 = a0; m.b0 = b0; m.op0 = op0;
    m.v1 = v1; m.a1 = a1; m.b1 = b1; m.op1 = op1;
    m.eid = eid; m.edata = edata;
    return m;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " alu_a"},       int'(b8.alu_a), 0);
    chk({tag, " alu_b"},       int'(b8.alu_b), 0);
    chk({tag, " alu_opcode"},  int'(b8.alu_opcode), 0);
    chk({tag, " rsp_id"},      int'(b8.rsp_id), 0);
    chk({tag, " rsp_data"},    int'(b8.rsp_data), 0);
    chk({tag, " rsp_valid"},   int'(b8.rsp_valid), 0);
    chk({tag, " disp_enable"}, int'(b8.disp_enable), 0);
    chk({tag, " busy"},        int'(b8.busy), 0);
    chk({tag, " req0_ready"},  int'(b8.req0_ready), 0);
    chk({tag, " req1_ready"},  int'(b8.req1_ready), 0);
  endtask

  task automatic wait_idle8(input string tag);
    int n = 0;
    while (b8.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " reached idle"}, int'(b8.busy), 0);
  endtask

  // Apply one table vector from IDLE (called at a negedge) and follow it
  // through EXEC and HOLD; returns at the negedge where IDLE is visible again.
  task automatic run_vec(input int idx, input vec_t v);
    int n, disp_n, pulses, stall, ea, eb, eop;
    string tag;
    tag = $sformatf("vec%0d", idx);
    b8.req0_valid = 1'(v.v0); b8.req0_a = 4'(v.a0); b8.req0_b = 4'(v.b0); b8.req0_op = 2'(v.op0);
    b8.req1_valid = 1'(v.v1); b8.req1_a = 4'(v.a1); b8.req1_b = 4'(v.b1); b8.req1_op = 2'(v.op1);
    ea  = (v.eid == 0) ? v.a0  : v.a1;
    eb  = (v.eid == 0) ? v.b0  : v.b1;
    eop = (v.eid == 0) ? v.op0 : v.op1;
    #1;
    chk({tag, " req0_ready"}, int'(b8.req0_ready), (v.eid == 0) ? 1 : 0);
    chk({tag, " req1_ready"}, int'(b8.req1_ready), (v.eid == 1) ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " alu_a"},      int'(b8.alu_a), ea);
    chk({tag, " alu_b"},      int'(b8.alu_b), eb);
    chk({tag, " alu_opcode"}, int'(b8.alu_opcode), eop);
    chk({tag, " exec rsp_id"}, int'(b8.rsp_id), v.eid);
    chk({tag, " exec busy"},  int'(b8.busy), 1);
    chk({tag, " exec disp"},  int'(b8.disp_enable), 0);
    if (v.eid == 0) b8.req0_valid = 1'b0;
    else            b8.req1_valid = 1'b0;
    n = 0; disp_n = 0; pulses = 0; stall = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, " rsp_valid"}, int'(b8.rsp_valid), 1);
        chk({tag, " rsp_data"},  int'(b8.rsp_data), v.edata);
        chk({tag, " rsp_id"},    int'(b8.rsp_id), v.eid);
      end
      if (b8.disp_enable) disp_n++;
      if (b8.rsp_valid) pulses++;
      if (b8.busy && (b8.req0_ready || b8.req1_ready)) stall++;
    end while (b8.busy && n < 30);
    chk({tag, " disp cycles"},  disp_n, 8);
    chk({tag, " rsp pulses"},   pulses, 1);
    chk({tag, " ready in hold"}, stall, 0);
    chk({tag, " idle after"},   n, 9);
    chk({tag, " rsp_data held"}, int'(b8.rsp_data), v.edata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int n, pulses, pulse_at, stall, disp_n;
    int d_a[3], d_b[3], d_op[3], d_exp[3];

    rst_n = 1'b0;
    b8.req0_valid = 0; b8.req0_a = 0; b8.req0_b = 0; b8.req0_op = 0;
    b8.req1_valid = 0; b8.req1_a = 0; b8.req1_b = 0; b8.req1_op = 0;
    b1.req0_valid = 0; b1.req0_a = 0; b1.req0_b = 0; b1.req0_op = 0;
    b1.req1_valid = 0; b1.req1_a = 0; b1.req1_b = 0; b1.req1_op = 0;

    vecs[0] = mk(1,  9,  9, 1,  1,  1, 2, 3,  0,  2); // first tie -> req0
    vecs[1] = mk(0,  0,  0, 0,  1,  1, 2, 3,  1,  3); // stalled req1 served
    vecs[2] = mk(1,  3,  4, 2,  1,  5, 6, 0,  0,  7); // tie, last=1 -> req0
    vecs[3] = mk(1, 15, 15, 1,  1,  5, 6, 0,  1, 11); // tie, last=0 -> req1
    vecs[4] = mk(1, 15, 15, 1,  0,  0, 0, 0,  0, 14); // wrap-around
    vecs[5] = mk(0,  0,  0, 0,  1,  8, 8, 2,  1,  0);
    vecs[6] = mk(1,  6,  9, 3,  0,  0, 0, 0,  0, 15);
    vecs[7] = mk(0,  0,  0, 0,  1, 10, 3, 2,  1, 13);

    // Reset state, with both valids asserted while rst_n is low.
    #2;
    b8.req0_valid = 1; b8.req1_valid = 1;
    #1;
    chk_zero_outputs("reset");
    b8.req0_valid = 0; b8.req1_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Stall: req1 appears during HOLD, gets ready only once IDLE is back,
    // i.e. transfer lands 10 edges after the req0 transfer.
    b8.req0_valid = 1; b8.req0_a = 3; b8.req0_b = 4; b8.req0_op = 2;
    #1;
    chk("stall req0_ready", int'(b8.req0_ready), 1);
    @(posedge clk);
    n = 0; pulses = 0; pulse_at = 0; stall = 0; disp_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("stall opcode", int'(b8.alu_opcode), 2);
        b8.req0_valid = 0;
      end
      if (n == 3) begin
        b8.req1_valid = 1; b8.req1_a = 5; b8.req1_b = 5; b8.req1_op = 1;
      end
      if (b8.rsp_valid) begin pulses++; pulse_at = n; end
      if (b8.disp_enable) disp_n++;
      if (b8.busy && b8.req1_ready) stall++;
    end while (!b8.req1_ready && n < 30);
    chk("stall ready edge", n, 10);
    chk("stall pulses", pulses, 1);
    chk("stall pulse cycle", pulse_at, 2);
    chk("stall no early ready", stall, 0);
    chk("stall disp cycles", disp_n, 8);
    @(posedge clk);
    @(negedge clk);
    chk("stall alu_a", int'(b8.alu_a), 5);
    chk("stall alu_opcode", int'(b8.alu_opcode), 1);
    chk("stall rsp_id", int'(b8.rsp_id), 1);
    b8.req1_valid = 0;
    @(negedge clk);
    chk("stall rsp_valid", int'(b8.rsp_valid), 1);
    chk("stall rsp_data", int'(b8.rsp_data), 10);
    wait_idle8("stall");

    // Reset in the 4th HOLD cycle of a req0 op (last_grant would be 0).
    @(negedge clk);
    b8.req0_valid = 1; b8.req0_a = 2; b8.req0_b = 3; b8.req0_op = 1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) b8.req0_valid = 0;
    end
    chk("midrst disp before", int'(b8.disp_enable), 1);
    b8.req0_valid = 1; b8.req0_a = 4; b8.req0_b = 5; b8.req0_op = 2;
    b8.req1_valid = 1; b8.req1_a = 6; b8.req1_b = 7; b8.req1_op = 3;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst tie req0_ready", int'(b8.req0_ready), 1);
    chk("midrst tie req1_ready", int'(b8.req1_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst alu_a", int'(b8.alu_a), 4);
    chk("midrst exec rsp_valid", int'(b8.rsp_valid), 0);
    chk("midrst exec rsp_data", int'(b8.rsp_data), 0);
    b8.req0_valid = 0;
    @(negedge clk);
    chk("midrst rsp_valid", int'(b8.rsp_valid), 1);
    chk("midrst rsp_data", int'(b8.rsp_data), 9);
    chk("midrst rsp_id", int'(b8.rsp_id), 0);
    wait_idle8("midrst");
    b8.req1_valid = 0;

    // HOLD_CYCLES=1: back-to-back ops from req0 every 3 cycles.
    d_a[0] = 15; d_b[0] = 15; d_op[0] = 0; d_exp[0] = 14;
    d_a[1] = 1;  d_b[1] = 1;  d_op[1] = 1; d_exp[1] = 2;
    d_a[2] = 7;  d_b[2] = 8;  d_op[2] = 2; d_exp[2] = 15;
    @(negedge clk);
    b1.req0_valid = 1; b1.req0_a = 4'(d_a[0]); b1.req0_b = 4'(d_b[0]); b1.req0_op = 2'(d_op[0]);
    #1;
    chk("h1 req0_ready", int'(b1.req0_ready), 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("h1 exec busy", int'(b1.busy), 1);
      chk("h1 exec disp", int'(b1.disp_enable), 0);
      chk("h1 alu_a", int'(b1.alu_a), d_a[k]);
      if (k < 2) begin
        b1.req0_a = 4'(d_a[k+1]); b1.req0_b = 4'(d_b[k+1]); b1.req0_op = 2'(d_op[k+1]);
      end else begin
        b1.req0_valid = 0;
      end
      @(negedge clk);
      chk("h1 rsp_valid", int'(b1.rsp_valid), 1);
      chk("h1 rsp_data", int'(b1.rsp_data), d_exp[k]);
      chk("h1 disp", int'(b1.disp_enable), 1);
      @(negedge clk);
      chk("h1 disp after", int'(b1.disp_enable), 0);
      chk("h1 busy after", int'(b1.busy), 0);
      chk("h1 next ready", int'(b1.req0_ready), (k < 2) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
